mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- Arbitrates the two requesters, sequences each memory transaction with a req/ack handshake, and returns read data.
- Drives the stall signals that freeze fetch or memory until its access completes.
- Data has priority; a streak limit prevents starvation of fetch. An ack-timeout flags a hung memory.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/arb_ack_timer.sv | 32 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline memory-port arbiter: state encoding,
// default bus widths and the grant-streak helper.
package pipeline_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int STREAK_W   = 4;
    localparam int TIMER_W    = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_e;

    typedef logic [STREAK_W-1:0] streak_t;

    function automatic streak_t streak_inc(input streak_t cur, input streak_t max);
        return (cur >= max) ? max : cur + streak_t'(1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the memory-port arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = pipeline_pkg::DEF_ADDR_W,
    parameter int DATA_W = pipeline_pkg::DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_f;
    logic              stall_m;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, dm_rdata, dm_done,
        output mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, dm_rdata, dm_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m, err
    );

endinterface

// File: rtl/arb_ack_timer.sv
// Clearable 8-bit cycle counter; tc flags the last grant cycle before the
// ack-timeout limit is reached. LIMIT of 0 disables the terminal count.
module arb_ack_timer
    import pipeline_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [TIMER_W-1:0] TC_VAL = (LIMIT > 0) ? TIMER_W'(LIMIT - 1) : '0;

    logic [TIMER_W-1:0] count;

    // NOTE: asynchronous reset sits in the sensitivity list; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + TIMER_W'(1);
        end
    end

    // Expiring on the LIMIT-th stalled cycle makes a timeout look like an ack at L = LIMIT-1.
    assign tc = (LIMIT > 0) && en && (count == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority; a grant-streak limit guarantees fetch forward progress.
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam streak_t STREAK_MAX = streak_t'(MAX_D_STREAK);

    arb_state_e        state;
    arb_state_e        state_next;
    streak_t           streak;
    logic              grant_i;
    logic              grant_d;
    logic              acked;
    logic              timed_out;
    logic              xfer_end;
    logic              in_grant;
    logic              timeout_tc;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] xfer_rdata;

    assign in_grant = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
    assign xfer_end = acked || timed_out;

    // Held clear outside the grant states, so every grant starts from zero.
    arb_ack_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_grant),
        .en    (in_grant),
        .tc    (timeout_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (bus.dm_req && !(bus.if_req && (streak == STREAK_MAX))) begin
                    grant_d    = 1'b1;
                    state_next = ARB_GRANT_D;
                end else if (bus.if_req) begin
                    grant_i    = 1'b1;
                    state_next = ARB_GRANT_I;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                // A real ack wins over a timeout landing in the same cycle.
                if (bus.mem_ack) begin
                    acked      = 1'b1;
                    state_next = ARB_RESP;
                end else if (timeout_tc) begin
                    timed_out  = 1'b1;
                    state_next = ARB_RESP;
                end
            end
            ARB_RESP: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    assign grant_addr = grant_d ? bus.dm_addr : bus.if_addr;
    assign xfer_rdata = acked ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.if_done   <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.dm_done <= 1'b0;

            if (grant_i || grant_d) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= grant_d && bus.dm_we;
                bus.mem_addr <= grant_addr;
            end
            if (grant_d) begin
                bus.mem_wdata <= bus.dm_wdata;
            end

            // Streak counts only data grants that made a waiting fetch wait longer.
            if (grant_i) begin
                streak <= '0;
            end else if (grant_d) begin
                streak <= bus.if_req ? streak_inc(streak, STREAK_MAX) : '0;
            end

            if (xfer_end) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
                if (state == ARB_GRANT_I) begin
                    bus.if_done  <= 1'b1;
                    bus.if_rdata <= xfer_rdata;
                end else begin
                    bus.dm_done <= 1'b1;
                    if (!bus.mem_we) begin
                        bus.dm_rdata <= xfer_rdata;
                    end
                end
            end

            if (timed_out) begin
                bus.err <= 1'b1;
            end
        end
    end

    assign bus.stall_f = bus.if_req && !bus.if_done;
    assign bus.stall_m = bus.dm_req && !bus.dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single/dual-requester
// transactions plus hand sequences for streak limit, ack timeout and async reset.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_D_STREAK (MAXS),
        .ACK_TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp        = 0;
    int          n_err        = 0;
    int          mem_lat      = 0;
    bit          mem_en       = 1'b1;
    bit          spurious_ack = 1'b0;
    bit          exp_err      = 1'b0;
    int          wait_cnt     = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        we;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        int          lat;
        logic        exp_first_d;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_addr2;
        logic [31:0] exp_ifr;
        logic [31:0] exp_dmr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_image(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h00500093;
            32'h14:  return 32'h00A00113;
            32'h200: return 32'h12345678;
            32'h300: return 32'hCAFEF00D;
            default: return ~a;
        endcase
    endfunction

    // Memory model: acks mem_lat cycles after mem_req rises, records writes.
    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_ack   = spurious_ack;
            bus.mem_rdata = spurious_ack ? 32'hBAD0BAD0 : 32'h0;
            wait_cnt      = 0;
        end else if (!mem_en) begin
            bus.mem_ack = 1'b0;
        end else if (wait_cnt >= mem_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = bus.mem_we ? 32'hBAD0BAD0 : mem_image(bus.mem_addr);
            if (bus.mem_we) begin
                last_wr_addr = bus.mem_addr;
                last_wr_data = bus.mem_wdata;
            end
        end else begin
            wait_cnt++;
        end
    end

    // Called at a negedge with the arbiter idle; returns at a negedge, idle again.
    task automatic run_vec(input vec_t v);
        int cyc;
        bit done_seen;
        bus.if_req   = v.ireq;
        bus.if_addr  = v.iaddr;
        bus.dm_req   = v.dreq;
        bus.dm_we    = v.we;
        bus.dm_addr  = v.daddr;
        bus.dm_wdata = v.wdata;
        mem_lat      = v.lat;
        #1;
        check("stall on request", 32'({bus.stall_f, bus.stall_m}), 32'({v.ireq, v.dreq}));
        cyc       = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("mem_req after grant", 32'(bus.mem_req), 32'd1);
                check("mem_addr of grant", bus.mem_addr, v.exp_addr);
                check("mem_we of grant", 32'(bus.mem_we), 32'(v.exp_we));
                if (v.exp_we) check("mem_wdata of write", bus.mem_wdata, v.wdata);
            end
            if (bus.if_done || bus.dm_done) done_seen = 1'b1;
            else check("stall while pending", 32'({bus.stall_f, bus.stall_m}), 32'({v.ireq, v.dreq}));
        end
        check("done latency", 32'(cyc), 32'(2 + v.lat));
        check("done select", 32'({bus.dm_done, bus.if_done}), v.exp_first_d ? 32'd2 : 32'd1);
        check("served stall low", 32'(v.exp_first_d ? bus.stall_m : bus.stall_f), 32'd0);
        if (v.exp_first_d) bus.dm_req = 1'b0;
        else               bus.if_req = 1'b0;

        if (v.ireq && v.dreq) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!bus.mem_req && cyc < 10);
            check("second grant delay", 32'(cyc), 32'd2);
            check("second grant addr", bus.mem_addr, v.exp_addr2);
            check("second grant we", 32'(bus.mem_we), 32'd0);
            cyc = 0;
            while (!(bus.if_done || bus.dm_done) && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("second done select", 32'({bus.dm_done, bus.if_done}), 32'd1);
            bus.if_req = 1'b0;
        end

        check("if_rdata", bus.if_rdata, v.exp_ifr);
        check("dm_rdata", bus.dm_rdata, v.exp_dmr);
        check("err", 32'(bus.err), 32'(exp_err));
        if (v.we) begin
            check("memory write addr", last_wr_addr, v.daddr);
            check("memory write data", last_wr_data, v.wdata);
        end
        @(negedge clk);
        check("done is one cycle", 32'({bus.if_done, bus.dm_done}), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   d_count;
        int   f_grants;
        logic prev_req;
        vec_t v;

        //            ireq  dreq  we    iaddr   daddr    wdata          lat firstD we   addr     addr2    if_rdata       dm_rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,   32'h0,         2, 1'b0, 1'b0, 32'h10,  32'h0,   32'h00500093, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h200, 32'h0,         0, 1'b1, 1'b0, 32'h200, 32'h0,   32'h00500093, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h300, 32'h0,         1, 1'b1, 1'b0, 32'h300, 32'h14,  32'h00A00113, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h40,  32'hDEADBEEF,  3, 1'b1, 1'b1, 32'h40,  32'h0,   32'h00A00113, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,   32'h0,         7, 1'b0, 1'b0, 32'h10,  32'h0,   32'h00500093, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h80, 32'h00000001,  0, 1'b1, 1'b1, 32'h80,  32'h200, 32'h12345678, 32'hCAFEF00D};

        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset mem_req", 32'(bus.mem_req), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        check("reset mem_wdata", bus.mem_wdata, 32'd0);
        check("reset done", 32'({bus.if_done, bus.dm_done}), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset if_rdata", bus.if_rdata, 32'd0);
        check("reset dm_rdata", bus.dm_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle stalls", 32'({bus.stall_f, bus.stall_m}), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Data held with fetch pending: fetch must win after exactly MAXS data grants, twice.
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h200;
        bus.if_addr = 32'h10;
        mem_lat     = 0;
        bus.dm_req  = 1'b1;
        bus.if_req  = 1'b1;
        d_count  = 0;
        f_grants = 0;
        cyc      = 0;
        prev_req = 1'b0;
        while (f_grants < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_req && !prev_req) begin
                if (bus.mem_addr == 32'h10) begin
                    f_grants++;
                    check("data grants before fetch", 32'(d_count), 32'(MAXS));
                    d_count = 0;
                    if (f_grants == 2) bus.dm_req = 1'b0;
                end else begin
                    d_count++;
                end
            end
            prev_req = bus.mem_req;
        end
        check("fetch grants under data load", 32'(f_grants), 32'd2);
        cyc = 0;
        while (!bus.if_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("streak fetch done", 32'(bus.if_done), 32'd1);
        check("streak fetch data", bus.if_rdata, 32'h00500093);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Hung memory: forced completion after TMO grant cycles, zero data, sticky err.
        mem_en      = 1'b0;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h300;
        bus.dm_req  = 1'b1;
        cyc = 0;
        while (!bus.dm_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout done latency", 32'(cyc), 32'(TMO + 1));
        check("timeout dm_rdata", bus.dm_rdata, 32'h0);
        check("timeout err", 32'(bus.err), 32'd1);
        bus.dm_req = 1'b0;
        mem_en     = 1'b1;
        exp_err    = 1'b1;

        // Spurious ack while idle must not start or finish anything.
        spurious_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("spurious ack idle", 32'({bus.mem_req, bus.if_done, bus.dm_done}), 32'd0);
        end
        spurious_ack = 1'b0;
        repeat (2) @(negedge clk);
        v = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h00A00113, 32'h0};
        run_vec(v);

        // Async reset while stuck in a data grant.
        mem_en      = 1'b0;
        bus.dm_addr = 32'h200;
        bus.dm_req  = 1'b1;
        repeat (3) @(negedge clk);
        check("stuck in grant", 32'(bus.mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async reset mem_req", 32'(bus.mem_req), 32'd0);
        check("async reset dm_done", 32'(bus.dm_done), 32'd0);
        check("async reset err", 32'(bus.err), 32'd0);
        check("async reset if_rdata", bus.if_rdata, 32'd0);
        @(negedge clk);
        bus.dm_req = 1'b0;
        mem_en     = 1'b1;
        exp_err    = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        v = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h12345678};
        run_vec(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
